// File: rtl/counter_nbit.sv
// Parametrised DMA up/down counter with programmable limit, step and four
// terminal-count modes; feeds the channel control FSM with carry/tc/done.
module counter_nbit #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              MR,
  input  logic [WIDTH-1:0]  data,
  input  logic              load,
  input  logic              dir,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  count,
  output logic              carry,
  output logic              tc_pulse,
  output logic              loadDone,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    M_WRAP    = 2'd0,
    M_SAT     = 2'd1,
    M_ONESHOT = 2'd2,
    M_RELOAD  = 2'd3
  } mode_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               tc_pulse_q, tc_pulse_d;
  logic               load_done_q, load_done_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     s_ext;
  logic [WIDTH:0]     up_sum;
  logic [WIDTH-1:0]   up_next;
  logic [WIDTH-1:0]   down_next;
  logic [WIDTH-1:0]   step_next;
  logic               term;
  logic               next_term;

  // Sums carried at WIDTH+1 bits so the clamp to limit/0 never sees overflow.
  always_comb begin
    s_ext     = (step == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(step);
    up_sum    = {1'b0, count_q} + s_ext;
    up_next   = (up_sum >= {1'b0, limit}) ? limit : up_sum[WIDTH-1:0];
    down_next = ({1'b0, count_q} < s_ext) ? '0 : count_q - s_ext[WIDTH-1:0];
    step_next = dir ? up_next : down_next;
    term      = dir ? (count_q >= limit) : (count_q == '0);
    next_term = dir ? (step_next >= limit) : (step_next == '0);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    tc_pulse_d  = 1'b0;
    load_done_d = 1'b0;
    if (MR) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (load) begin
      state_d     = S_IDLE;
      count_d     = data;
      load_done_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: if (en) state_d = S_COUNT;
        S_COUNT: begin
          if (!en) begin
            state_d = S_IDLE;
          end else if (term) begin
            unique case (mode_e'(mode))
              M_WRAP:    count_d = dir ? '0 : limit;
              M_SAT:     count_d = count_q;
              M_ONESHOT: state_d = S_DONE;
              M_RELOAD:  count_d = data;
              default:   count_d = count_q;
            endcase
          end else begin
            count_d    = step_next;
            tc_pulse_d = next_term;
            if (next_term && mode_e'(mode) == M_ONESHOT) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_COUNT);
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    count_q     <= count_d;
    tc_pulse_q  <= tc_pulse_d;
    load_done_q <= load_done_d;
    done_q      <= done_d;
    busy_q      <= busy_d;
  end

  assign count    = count_q;
  assign carry    = term & ~MR;
  assign tc_pulse = tc_pulse_q;
  assign loadDone = load_done_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_counter_nbit.sv
// Scoreboard bench for counter_nbit: directed stimulus pushes hand-computed
// post-edge expectations, a monitor pops and compares them after each edge.
module tb_counter_nbit;

  localparam int unsigned WIDTH  = 10;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              MR, load, dir, en;
  logic [WIDTH-1:0]  data, limit;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  count;
  logic              carry, tc_pulse, loadDone, done, busy;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             tc;
    logic             ld;
    logic             done;
    logic             busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  counter_nbit #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .MR(MR), .data(data), .load(load), .dir(dir), .en(en),
    .step(step), .limit(limit), .mode(mode), .count(count), .carry(carry),
    .tc_pulse(tc_pulse), .loadDone(loadDone), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int v, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, v, act, exp);
    end
  endtask

  // Monitor: outputs settle after each rising edge; compare once per edge.
  initial begin
    exp_t e;
    int   v;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        v = vec;
        chk("count",    v, count,                 e.count);
        chk("carry",    v, WIDTH'(carry),         WIDTH'(e.carry));
        chk("tc_pulse", v, WIDTH'(tc_pulse),      WIDTH'(e.tc));
        chk("loadDone", v, WIDTH'(loadDone),      WIDTH'(e.ld));
        chk("done",     v, WIDTH'(done),          WIDTH'(e.done));
        chk("busy",     v, WIDTH'(busy),          WIDTH'(e.busy));
      end
    end
  end

  // Apply the current inputs at one edge and queue the expected result.
  task automatic tick(input logic [WIDTH-1:0] c, input logic cy, input logic tc,
                      input logic ld, input logic dn, input logic bs);
    exp_t e;
    e.count = c; e.carry = cy; e.tc = tc; e.ld = ld; e.done = dn; e.busy = bs;
    @(posedge clk);
    vec++;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    MR = 1'b1; load = 1'b0; dir = 1'b1; en = 1'b0; data = '0;
    limit = 10'h3FF; step = 4'd1; mode = 2'd0;
    @(negedge clk);

    // 1: reset and load
    tick(10'h000, 0, 0, 0, 0, 0);
    tick(10'h000, 0, 0, 0, 0, 0);
    MR = 1'b0; load = 1'b1; data = 10'h2F0;
    tick(10'h2F0, 0, 0, 1, 0, 0);
    load = 1'b0;
    tick(10'h2F0, 0, 0, 0, 0, 0);

    // 2: WRAP up, limit 5
    mode = 2'd0; dir = 1'b1; limit = 10'd5; step = 4'd1; data = '0; load = 1'b1;
    tick(10'd0, 0, 0, 1, 0, 0);
    load = 1'b0; en = 1'b1;
    tick(10'd0, 0, 0, 0, 0, 1);
    tick(10'd1, 0, 0, 0, 0, 1);
    tick(10'd2, 0, 0, 0, 0, 1);
    tick(10'd3, 0, 0, 0, 0, 1);
    tick(10'd4, 0, 0, 0, 0, 1);
    tick(10'd5, 1, 1, 0, 0, 1);
    tick(10'd0, 0, 0, 0, 0, 1);
    tick(10'd1, 0, 0, 0, 0, 1);
    en = 1'b0;
    tick(10'd1, 0, 0, 0, 0, 0);

    // 3: SAT down, step 3 from 7
    mode = 2'd1; dir = 1'b0; step = 4'd3; data = 10'd7; load = 1'b1;
    tick(10'd7, 0, 0, 1, 0, 0);
    load = 1'b0; en = 1'b1;
    tick(10'd7, 0, 0, 0, 0, 1);
    tick(10'd4, 0, 0, 0, 0, 1);
    tick(10'd1, 0, 0, 0, 0, 1);
    tick(10'd0, 1, 1, 0, 0, 1);
    tick(10'd0, 1, 0, 0, 0, 1);
    tick(10'd0, 1, 0, 0, 0, 1);
    en = 1'b0;
    tick(10'd0, 1, 0, 0, 0, 0);

    // 4: ONESHOT up with clamp to 0x3FF
    mode = 2'd2; dir = 1'b1; limit = 10'h3FF; step = 4'd4; data = 10'h3F8; load = 1'b1;
    tick(10'h3F8, 0, 0, 1, 0, 0);
    load = 1'b0; en = 1'b1;
    tick(10'h3F8, 0, 0, 0, 0, 1);
    tick(10'h3FC, 0, 0, 0, 0, 1);
    tick(10'h3FF, 1, 1, 0, 1, 0);
    tick(10'h3FF, 1, 0, 0, 1, 0);
    dir = 1'b0; step = 4'd1;
    tick(10'h3FF, 0, 0, 0, 1, 0);
    data = 10'h010; load = 1'b1;
    tick(10'h010, 0, 0, 1, 0, 0);
    load = 1'b0; en = 1'b0;
    tick(10'h010, 0, 0, 0, 0, 0);

    // 5: RELOAD down from 3
    mode = 2'd3; dir = 1'b0; step = 4'd1; data = 10'd3; load = 1'b1;
    tick(10'd3, 0, 0, 1, 0, 0);
    load = 1'b0; en = 1'b1;
    tick(10'd3, 0, 0, 0, 0, 1);
    tick(10'd2, 0, 0, 0, 0, 1);
    tick(10'd1, 0, 0, 0, 0, 1);
    tick(10'd0, 1, 1, 0, 0, 1);
    tick(10'd3, 0, 0, 0, 0, 1);
    tick(10'd2, 0, 0, 0, 0, 1);
    tick(10'd1, 0, 0, 0, 0, 1);
    tick(10'd0, 1, 1, 0, 0, 1);
    tick(10'd3, 0, 0, 0, 0, 1);
    en = 1'b0;
    tick(10'd3, 0, 0, 0, 0, 0);

    // 6: simultaneous events at 0x100, step 0 as 1
    mode = 2'd0; dir = 1'b1; limit = 10'h3FF; step = 4'd1; data = 10'h100; load = 1'b1;
    tick(10'h100, 0, 0, 1, 0, 0);
    load = 1'b0; en = 1'b1;
    tick(10'h100, 0, 0, 0, 0, 1);
    step = 4'd0;
    tick(10'h101, 0, 0, 0, 0, 1);
    MR = 1'b1; load = 1'b1;
    tick(10'h000, 0, 0, 0, 0, 0);
    MR = 1'b0; data = 10'h100;
    tick(10'h100, 0, 0, 1, 0, 0);
    load = 1'b0;
    tick(10'h100, 0, 0, 0, 0, 1);
    data = 10'h055; load = 1'b1;
    tick(10'h055, 0, 0, 1, 0, 0);

    // reset out of DONE, ONESHOT entered already terminal
    mode = 2'd2; limit = 10'h056; load = 1'b0;
    tick(10'h055, 0, 0, 0, 0, 1);
    tick(10'h056, 1, 1, 0, 1, 0);
    MR = 1'b1;
    tick(10'h000, 0, 0, 0, 0, 0);
    MR = 1'b0; dir = 1'b0;
    tick(10'h000, 1, 0, 0, 0, 1);
    tick(10'h000, 1, 0, 0, 1, 0);
    MR = 1'b1;
    tick(10'h000, 0, 0, 0, 0, 0);

    // WRAP down jumps to limit; step 2 clamps to 0
    MR = 1'b0; mode = 2'd0; dir = 1'b0; limit = 10'd5; step = 4'd1;
    tick(10'd0, 1, 0, 0, 0, 1);
    tick(10'd5, 0, 0, 0, 0, 1);
    step = 4'd2;
    tick(10'd3, 0, 0, 0, 0, 1);
    tick(10'd1, 0, 0, 0, 0, 1);
    tick(10'd0, 1, 1, 0, 0, 1);
    en = 1'b0;
    tick(10'd0, 1, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_nbit.md
Name: counter_nbit

Overview:
Parametrised up/down counter with programmable terminal value, step size and four terminal-count modes (wrap, saturate, one-shot, auto-reload). It generalises the 10-bit DMA transfer/address counter to any width. It adds modulo-limit wrap, multi-step increments and a registered terminal-count pulse for DMA channel sequencing. It sits between the DMA register file (data, limit, step, mode) and the channel control FSM (en, carry, tc_pulse, done).

Parameters:
WIDTH, 10, counter/data/limit width in bits (>=2)
STEP_W, 4, width of step input (1..WIDTH)

Ports:
clk  input  1  rising-edge clock
MR  input  1  master reset; synchronous, active-high
data  input  WIDTH  parallel load / reload value
load  input  1  active-high load request, sampled at edge
dir  input  1  1 = count up, 0 = count down
en  input  1  count enable
step  input  STEP_W  increment magnitude; 0 treated as 1
limit  input  WIDTH  terminal value for up-count; wrap target for down-count
mode  input  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 RELOAD
count  output  WIDTH  registered counter value
carry  output  1  combinational terminal flag
tc_pulse  output  1  registered, 1-cycle pulse on stepping into terminal
loadDone  output  1  registered, 1-cycle pulse after a load
done  output  1  registered, high while in DONE state
busy  output  1  registered, high while in COUNT state

Behaviour:
- Single clock domain. One clock and one reset only: clk, with reset MR, synchronous and active-high.
- States: IDLE, COUNT, DONE (2-bit encoding).
- Edge priority: MR > load > state logic.
- MR=1 at an edge: state IDLE; count=0; tc_pulse, loadDone, done, busy = 0. This is the reset value of every registered output. Reset mid-operation, including in DONE, takes effect at the same edge.
- load=1 (MR=0): count<=data; loadDone<=1 for exactly one cycle; state<=IDLE; tc_pulse<=0. Load overrides en in any state and is the only non-reset exit from DONE.
- Terminal condition T:
  - dir=1: T = (count >= limit).
  - dir=0: T = (count == 0).
- carry = T & ~MR, combinational. limit and dir changes affect carry immediately.
- Effective step s = (step==0) ? 1 : step, zero-extended. Sums are computed at WIDTH+1 bits.
- Step, non-terminal:
  - Up: next = min(count+s, limit).
  - Down: next = (count < s) ? 0 : count-s.
  - Clamping guarantees the terminal value is always hit exactly.
- Step at terminal (T=1), by mode:
  - WRAP: up -> 0; down -> limit. This gives a modulo-(limit+1) counter.
  - SAT: count holds; state stays COUNT.
  - ONESHOT: the counter never steps here. Reaching T moves to DONE (see below).
  - RELOAD: count<=data; loadDone not asserted.
- IDLE:
  - en=1 -> COUNT; count unchanged. This is the one-cycle start latency.
  - en=0 -> stay IDLE.
- COUNT:
  - en=1 -> perform one step per edge.
  - en=0 -> IDLE; count holds.
  - ONESHOT: the edge whose step makes next terminal also sets state DONE and done=1.
  - ONESHOT entered already at T: go to DONE at the first en=1 edge; count holds.
- DONE: count holds; en, dir and step are ignored; done=1 until load or MR.
- tc_pulse<=1 on an edge in COUNT with en=1 where current count is not terminal and next count is terminal under the current dir. Otherwise tc_pulse<=0, so it never repeats while held in SAT. Wrap and reload steps themselves do not pulse.
- busy = (state==COUNT), registered with the state.
- dir, step or mode changes in COUNT take effect on the next step edge. No glitch handling is required.

Test Plan:
1. MR=1 two cycles -> count=0x000, all flags 0. Then MR=0, load=1, data=0x2F0 for one cycle -> next cycle count=0x2F0, loadDone=1 for one cycle only.
2. WRAP, dir=1, limit=5, step=1, load 0, en held -> count 0 (start cycle), 1,2,3,4,5,0,1. tc_pulse=1 exactly in the cycle count shows 5. carry=1 while count=5.
3. SAT, dir=0, step=3, load 7, en held -> 7,7(start),4,1,0,0,0. tc_pulse once at 0, carry stays 1, busy stays 1.
4. ONESHOT, dir=1, limit=0x3FF, step=4, load 0x3F8, en held -> 0x3FC, 0x3FF (clamped), then DONE: done=1, busy=0, count frozen despite en. load 0x010 -> done=0, count=0x010, state IDLE.
5. RELOAD, dir=0, step=1, data=3, load then en held -> 3,3,2,1,0,3,2. carry=1 at each 0. tc_pulse on each entry to 0. loadDone only after the explicit load.
6. Simultaneous events in COUNT at count=0x100:
   - MR=1 with load=1 -> count=0 (reset wins).
   - load=1 with en=1 -> count=data, state IDLE.
   - step=0 -> behaves as step=1.
